multdiv_iter: RTL and testbench

MULTDIV_ITER -- requirements
Module: multdiv_iter

---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/multdiv_step.sv | 36 +++
 rtl/multdiv_iter.sv | 198 +++++++++++++++++++
 tb/tb_multdiv_iter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM and op
// encodings plus the fixed start-to-ready latency as a function of width.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // Cycles from the start edge to the edge that raises data_resultRDY.
    function automatic int unsigned lat_cycles(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/multdiv_step.sv
// One radix-2 iteration: shift-add for multiply, non-restoring
// subtract/add-and-shift for divide, both on operand magnitudes.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_t              i_op,
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_mul_sum;
    logic [WIDTH:0] w_div_shift;
    logic [WIDTH:0] w_div_sum;

    always_comb begin
        w_mul_sum   = {1'b0, i_acc[WIDTH-1:0]} + (i_lo[0] ? {1'b0, i_m} : '0);
        // The partial remainder's true value always fits WIDTH+1 bits after
        // the add/subtract, so modular arithmetic here is exact.
        w_div_shift = {i_acc[WIDTH-1:0], i_lo[WIDTH-1]};
        w_div_sum   = i_acc[WIDTH] ? (w_div_shift + {1'b0, i_m})
                                   : (w_div_shift - {1'b0, i_m});
        if (i_op == OP_MULT) begin
            o_acc = {1'b0, w_mul_sum[WIDTH:1]};
            o_lo  = {w_mul_sum[0], i_lo[WIDTH-1:1]};
        end else begin
            o_acc = w_div_sum;
            o_lo  = {i_lo[WIDTH-2:0], ~w_div_sum[WIDTH]};
        end
    end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed/unsigned multiplier-divider with fixed WIDTH+2 latency:
// one conditioning cycle, WIDTH radix-2 steps, one sign-correction cycle.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit SIGNED_DEFAULT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_high,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned LAT = lat_cycles(WIDTH);
    localparam int          CW  = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_SETUP = '0;
    localparam logic [CW-1:0] CNT_FIX   = CW'(LAT - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    op_t              r_op;
    logic             r_signed;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   r_acc;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_dbz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_high;
    logic             r_exc;
    logic             r_rdy;

    logic             w_start;
    logic             w_setup;
    logic             w_step;
    logic             w_fix;
    logic [WIDTH:0]   w_step_acc;
    logic [WIDTH-1:0] w_step_lo;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic             w_mul_exc;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_start = ctrl_MULT | ctrl_DIV;

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .i_op  (r_op),
        .i_acc (r_acc),
        .i_lo  (r_lo),
        .i_m   (r_m),
        .o_acc (w_step_acc),
        .o_lo  (w_step_lo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A start from any state restarts; landing on the fix cycle aborts silently.
    always_comb begin
        w_state_next = r_state;
        w_setup      = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            ST_IDLE: w_state_next = ST_IDLE;
            ST_RUN: begin
                if (r_cnt == CNT_SETUP) begin
                    w_setup = 1'b1;
                end else if (r_cnt == CNT_FIX) begin
                    w_fix        = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (w_start) begin
            w_state_next = ST_RUN;
            w_setup      = 1'b0;
            w_step       = 1'b0;
            w_fix        = 1'b0;
        end
    end

    always_comb begin
        w_a_neg   = r_signed & r_a[WIDTH-1];
        w_b_neg   = r_signed & r_b[WIDTH-1];
        w_a_mag   = w_a_neg ? (~r_a + 1'b1) : r_a;
        w_b_mag   = w_b_neg ? (~r_b + 1'b1) : r_b;
        w_prod    = {r_acc[WIDTH-1:0], r_lo};
        w_prod_s  = r_neg_lo ? (~w_prod + 1'b1) : w_prod;
        w_mul_exc = r_signed ? (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}})
                             : (w_prod_s[2*WIDTH-1:WIDTH] != '0);
        // Final non-restoring correction: a negative remainder gets the divisor back.
        w_rem_mag = r_acc[WIDTH] ? (r_acc[WIDTH-1:0] + r_m) : r_acc[WIDTH-1:0];
        w_quot    = r_neg_lo ? (~r_lo + 1'b1) : r_lo;
        w_rem     = r_neg_hi ? (~w_rem_mag + 1'b1) : w_rem_mag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_op     <= OP_MULT;
            r_signed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_high   <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start) begin
                r_op     <= ctrl_MULT ? OP_MULT : OP_DIV;
                r_signed <= ctrl_signed & SIGNED_DEFAULT;
                r_a      <= data_operandA;
                r_b      <= data_operandB;
                r_cnt    <= '0;
            end else begin
                if (w_setup || w_step) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_setup) begin
                    r_acc    <= '0;
                    r_lo     <= w_a_mag;
                    r_m      <= w_b_mag;
                    r_neg_lo <= w_a_neg ^ w_b_neg;
                    r_neg_hi <= w_a_neg;
                    r_dbz    <= (r_op == OP_DIV) && (r_b == '0);
                    r_ovf    <= (r_op == OP_DIV) && r_signed && (r_a == MIN_NEG) && (r_b == '1);
                end
                if (w_step) begin
                    r_acc <= w_step_acc;
                    r_lo  <= w_step_lo;
                end
                if (w_fix) begin
                    r_rdy <= 1'b1;
                    if (r_op == OP_MULT) begin
                        r_result <= w_prod_s[WIDTH-1:0];
                        r_high   <= w_prod_s[2*WIDTH-1:WIDTH];
                        r_exc    <= w_mul_exc;
                    end else if (r_dbz) begin
                        r_result <= '0;
                        r_high   <= '0;
                        r_exc    <= 1'b1;
                    end else begin
                        r_result <= w_quot;
                        r_high   <= w_rem;
                        r_exc    <= r_ovf;
                    end
                end
            end
        end
    end

    assign data_result    = r_result;
    assign data_high      = r_high;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench: directed cases at WIDTH=32, randomized cases at
// WIDTH=32 and WIDTH=8 against a plain-arithmetic reference model.
module tb_multdiv_iter;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    logic [31:0] a32, b32, res32, hi32;
    logic        mult32, div32, sgn32, exc32, rdy32, busy32;
    logic [7:0]  a8, b8, res8, hi8;
    logic        mult8, div8, sgn8, exc8, rdy8, busy8;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] o_res, o_hi;
    logic        o_exc;
    int          o_lat;

    multdiv_iter #(.WIDTH(32), .SIGNED_DEFAULT(1'b1)) dut32 (
        .clock(clock), .reset(reset),
        .data_operandA(a32), .data_operandB(b32),
        .ctrl_MULT(mult32), .ctrl_DIV(div32), .ctrl_signed(sgn32),
        .data_result(res32), .data_high(hi32), .data_exception(exc32),
        .data_resultRDY(rdy32), .busy(busy32)
    );

    multdiv_iter #(.WIDTH(8), .SIGNED_DEFAULT(1'b1)) dut8 (
        .clock(clock), .reset(reset),
        .data_operandA(a8), .data_operandB(b8),
        .ctrl_MULT(mult8), .ctrl_DIV(div8), .ctrl_signed(sgn8),
        .data_result(res8), .data_high(hi8), .data_exception(exc8),
        .data_resultRDY(rdy8), .busy(busy8)
    );

    // Reference: exact integer arithmetic on sign- or zero-extended operands.
    function automatic void ref_model(input int w, input bit is_div, input bit sgn,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic [31:0] hi,
                                      output bit exc);
        longint mask, sa, sb, p, q, r, lo_lim, hi_lim;
        mask   = (longint'(1) << w) - 1;
        sa     = longint'(a) & mask;
        sb     = longint'(b) & mask;
        if (sgn) begin
            sa = (sa << (64 - w)) >>> (64 - w);
            sb = (sb << (64 - w)) >>> (64 - w);
        end
        lo_lim = -(longint'(1) << (w - 1));
        hi_lim = (longint'(1) << (w - 1)) - 1;
        if (!is_div) begin
            p   = sa * sb;
            res = 32'(p & mask);
            hi  = 32'((p >> w) & mask);
            exc = sgn ? (p < lo_lim || p > hi_lim) : (((p >> w) & mask) != 0);
        end else if (sb == 0) begin
            res = 32'd0; hi = 32'd0; exc = 1'b1;
        end else if (sgn && sa == lo_lim && sb == -1) begin
            res = 32'(sa & mask); hi = 32'd0; exc = 1'b1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = 32'(q & mask);
            hi  = 32'(r & mask);
            exc = 1'b0;
        end
    endfunction

    task automatic run_op32(input bit is_div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        a32 = a; b32 = b; mult32 = !is_div; div32 = is_div; sgn32 = sgn;
        @(posedge clock);
        #1;
        mult32 = 1'b0; div32 = 1'b0;
        o_lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clock);
            #1;
            if (rdy32) begin
                o_lat = n; o_res = res32; o_hi = hi32; o_exc = exc32;
                break;
            end
        end
    endtask

    task automatic run_op8(input bit is_div, input bit sgn, input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        a8 = a; b8 = b; mult8 = !is_div; div8 = is_div; sgn8 = sgn;
        @(posedge clock);
        #1;
        mult8 = 1'b0; div8 = 1'b0;
        o_lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (rdy8) begin
                o_lat = n; o_res = {24'd0, res8}; o_hi = {24'd0, hi8}; o_exc = exc8;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; a32 = 32'd5; b32 = 32'd5; mult32 = 1'b1; a8 = 8'd5; b8 = 8'd5; mult8 = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if ({busy32, rdy32, exc32, res32, hi32} !== 67'd0) begin
            n_errors++;
            $display("FAIL reset32: busy=%0d rdy=%0d exc=%0d res=%h hi=%h, expected all 0",
                     busy32, rdy32, exc32, res32, hi32);
        end
        n_checks++;
        if ({busy8, rdy8, exc8, res8, hi8} !== 19'd0) begin
            n_errors++;
            $display("FAIL reset8: busy=%0d rdy=%0d exc=%0d res=%h hi=%h, expected all 0",
                     busy8, rdy8, exc8, res8, hi8);
        end
        @(negedge clock);
        reset = 1'b0; mult32 = 1'b0; mult8 = 1'b0;
        $display("reset: busy32=%0d busy8=%0d", busy32, busy8);
    endtask

    task automatic test_mult();
        logic [31:0] ea [3], eb [3], er [3], eh [3];
        bit          es [3], ee [3];
        ea = '{32'd6, 32'h0001_0000, 32'h0001_0000};
        eb = '{32'hFFFF_FFF9, 32'h0001_0000, 32'h0001_0000};
        es = '{1'b1, 1'b1, 1'b0};
        er = '{32'hFFFF_FFD6, 32'd0, 32'd0};
        eh = '{32'hFFFF_FFFF, 32'd1, 32'd1};
        ee = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op32(1'b0, es[i], ea[i], eb[i]);
            $display("mult s=%0d %h x %h -> res=%h hi=%h exc=%0d lat=%0d", es[i], ea[i], eb[i], o_res, o_hi, o_exc, o_lat);
            n_checks++;
            if (o_lat !== 34) begin
                n_errors++;
                $display("FAIL mult_lat[%0d]: got %0d, expected 34", i, o_lat);
            end
            n_checks++;
            if ({o_res, o_hi, o_exc} !== {er[i], eh[i], ee[i]}) begin
                n_errors++;
                $display("FAIL mult_val[%0d]: got res=%h hi=%h exc=%0d, expected res=%h hi=%h exc=%0d",
                         i, o_res, o_hi, o_exc, er[i], eh[i], ee[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] ea [4], eb [4], er [4], eh [4];
        bit          es [4], ee [4];
        ea = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        eb = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
        es = '{1'b1, 1'b0, 1'b1, 1'b1};
        er = '{32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000};
        eh = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        ee = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op32(1'b1, es[i], ea[i], eb[i]);
            $display("div s=%0d %h / %h -> res=%h hi=%h exc=%0d lat=%0d", es[i], ea[i], eb[i], o_res, o_hi, o_exc, o_lat);
            n_checks++;
            if (o_lat !== 34) begin
                n_errors++;
                $display("FAIL div_lat[%0d]: got %0d, expected 34", i, o_lat);
            end
            n_checks++;
            if ({o_res, o_hi, o_exc} !== {er[i], eh[i], ee[i]}) begin
                n_errors++;
                $display("FAIL div_val[%0d]: got res=%h hi=%h exc=%0d, expected res=%h hi=%h exc=%0d",
                         i, o_res, o_hi, o_exc, er[i], eh[i], ee[i]);
            end
        end
    endtask

    task automatic test_hold();
        run_op32(1'b0, 1'b0, 32'd7, 32'd9);
        @(posedge clock);
        #1;
        n_checks++;
        if ({rdy32, busy32, res32} !== {1'b0, 1'b0, 32'd63}) begin
            n_errors++;
            $display("FAIL rdy_pulse: got rdy=%0d busy=%0d res=%0d, expected rdy=0 busy=0 res=63", rdy32, busy32, res32);
        end
        @(negedge clock);
        a32 = 32'd2; b32 = 32'd2; mult32 = 1'b1; sgn32 = 1'b0;
        @(negedge clock);
        mult32 = 1'b0;
        repeat (5) @(negedge clock);
        n_checks++;
        if ({busy32, res32} !== {1'b1, 32'd63}) begin
            n_errors++;
            $display("FAIL hold_busy: got busy=%0d res=%0d, expected busy=1 res=63", busy32, res32);
        end
        $display("hold: busy=%0d res=%0d", busy32, res32);
        repeat (40) @(posedge clock);
    endtask

    task automatic test_back_to_back();
        int rdy_seen;
        rdy_seen = 0;
        @(negedge clock);
        a32 = 32'd3; b32 = 32'd3; mult32 = 1'b1; sgn32 = 1'b1;
        @(posedge clock);
        #1;
        mult32 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clock);
            #1;
            if (rdy32) rdy_seen++;
        end
        run_op32(1'b1, 1'b1, 32'd9, 32'd3);
        $display("restart: div 9/3 -> res=%0d lat=%0d early_rdy=%0d", o_res, o_lat, rdy_seen);
        n_checks++;
        if ({o_lat, o_res, rdy_seen} !== {32'd34, 32'd3, 32'd0}) begin
            n_errors++;
            $display("FAIL restart: got lat=%0d res=%0d early_rdy=%0d, expected lat=34 res=3 early_rdy=0",
                     o_lat, o_res, rdy_seen);
        end
    endtask

    task automatic test_reset_mid();
        int rdy_seen;
        rdy_seen = 0;
        @(negedge clock);
        a32 = 32'd123; b32 = 32'd45; mult32 = 1'b1; sgn32 = 1'b0;
        @(negedge clock);
        mult32 = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if ({busy32, rdy32, exc32, res32, hi32} !== 67'd0) begin
            n_errors++;
            $display("FAIL reset_mid: busy=%0d rdy=%0d exc=%0d res=%h hi=%h, expected all 0",
                     busy32, rdy32, exc32, res32, hi32);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (rdy32) rdy_seen++;
        end
        n_checks++;
        if (rdy_seen !== 0) begin
            n_errors++;
            $display("FAIL reset_no_rdy: got %0d pulses, expected 0", rdy_seen);
        end
        run_op32(1'b0, 1'b0, 32'd123, 32'd45);
        $display("after reset: mult 123x45 -> res=%0d lat=%0d", o_res, o_lat);
        n_checks++;
        if ({o_lat, o_res, o_hi, o_exc} !== {32'd34, 32'd5535, 32'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL post_reset: got lat=%0d res=%0d hi=%0d exc=%0d, expected lat=34 res=5535 hi=0 exc=0",
                     o_lat, o_res, o_hi, o_exc);
        end
    endtask

    task automatic test_random32();
        logic [31:0] edges [5];
        logic [31:0] a, b, er, eh;
        bit          is_div, sgn, ee;
        edges = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        for (int i = 0; i < 150; i++) begin
            is_div = 1'($urandom_range(0, 1));
            sgn    = 1'($urandom_range(0, 1));
            a      = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            b      = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
            ref_model(32, is_div, sgn, a, b, er, eh, ee);
            run_op32(is_div, sgn, a, b);
            $display("rand32 %s s=%0d %h %h -> res=%h hi=%h exc=%0d lat=%0d", is_div ? "div" : "mul",
                     sgn, a, b, o_res, o_hi, o_exc, o_lat);
            n_checks++;
            if ({o_lat, o_res, o_hi, o_exc} !== {32'd34, er, eh, ee}) begin
                n_errors++;
                $display("FAIL rand32[%0d]: got lat=%0d res=%h hi=%h exc=%0d, expected lat=34 res=%h hi=%h exc=%0d",
                         i, o_lat, o_res, o_hi, o_exc, er, eh, ee);
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0]  a, b;
        logic [31:0] er, eh;
        bit          is_div, sgn, ee;
        for (int i = 0; i < 1000; i++) begin
            is_div = 1'($urandom_range(0, 1));
            sgn    = 1'($urandom_range(0, 1));
            a      = 8'($urandom);
            b      = 8'($urandom);
            ref_model(8, is_div, sgn, {24'd0, a}, {24'd0, b}, er, eh, ee);
            run_op8(is_div, sgn, a, b);
            $display("rand8 %s s=%0d %h %h -> res=%h hi=%h exc=%0d lat=%0d", is_div ? "div" : "mul",
                     sgn, a, b, o_res[7:0], o_hi[7:0], o_exc, o_lat);
            n_checks++;
            if ({o_lat, o_res, o_hi, o_exc} !== {32'd10, er, eh, ee}) begin
                n_errors++;
                $display("FAIL rand8[%0d]: got lat=%0d res=%h hi=%h exc=%0d, expected lat=10 res=%h hi=%h exc=%0d",
                         i, o_lat, o_res, o_hi, o_exc, er, eh, ee);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        a32 = '0; b32 = '0; mult32 = 1'b0; div32 = 1'b0; sgn32 = 1'b0;
        a8 = '0; b8 = '0; mult8 = 1'b0; div8 = 1'b0; sgn8 = 1'b0;
        o_res = '0; o_hi = '0; o_exc = 1'b0; o_lat = 0;
        repeat (3) @(posedge clock);
        test_reset();
        test_mult();
        test_div();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random32();
        test_random8();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
